// File: rtl/pipe_pkg.sv
// Shared definitions for the decode/execute pipeline stage register:
// default payload widths, control-field layout and the stage state encoding.
package pipe_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_CTRL_W = 16;

  // Control payload layout, LSB first.
  localparam int ALU_OP_OFF           = 0;
  localparam int ALU_OP_W             = 5;
  localparam int BRANCH_JUMP_OFF      = ALU_OP_OFF + ALU_OP_W;
  localparam int BRANCH_JUMP_W        = 2;
  localparam int OP_SEL_OFF           = BRANCH_JUMP_OFF + BRANCH_JUMP_W;
  localparam int OP_SEL_W             = 1;
  localparam int MEM_WRITE_OFF        = OP_SEL_OFF + OP_SEL_W;
  localparam int MEM_WRITE_W          = 2;
  localparam int MEM_READ_OFF         = MEM_WRITE_OFF + MEM_WRITE_W;
  localparam int MEM_READ_W           = 2;
  localparam int REG_WRITE_SEL_OFF    = MEM_READ_OFF + MEM_READ_W;
  localparam int REG_WRITE_SEL_W      = 2;
  localparam int REG_WRITE_ENABLE_OFF = REG_WRITE_SEL_OFF + REG_WRITE_SEL_W;
  localparam int REG_WRITE_ENABLE_W   = 1;

  // Number of held entries doubles as the state encoding.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;

  function automatic logic [1:0] occupancy_of(input stage_state_e s);
    case (s)
      ST_ONE:  return 2'd1;
      ST_FULL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One payload slot: a valid bit plus datapath/control registers.
// clear drops the valid bit but keeps the payload; load captures new payload.
module pipe_slot #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  // Next slot contents: clear wins over load.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and a latch is inferred.
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = in_data;
      ctrl_d  = in_ctrl;
    end
  end

  // Slot registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: the payload is reset as well as the valid bit, because a freshly reset stage must present an all-zero OUT_DATA.
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign ctrl  = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush and an optional
// skid slot. With SKID_EN=1 IN_READY is a flop, breaking the ready path.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int CTRL_W  = DEFAULT_CTRL_W,
  parameter int SKID_EN = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic [CTRL_W-1:0] IN_CTRL,
  input  logic              FLUSH,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [CTRL_W-1:0] OUT_CTRL,
  output logic [1:0]        OCCUPANCY
);

  stage_state_e      state_q, state_d;
  logic              in_fire, out_fire;
  logic              in_ready_d;
  logic              main_load, main_clear, skid_load, skid_clear;
  logic              main_valid, skid_valid;
  logic [DATA_W-1:0] main_data, skid_data, main_in_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_in_ctrl;

  assign in_fire  = IN_VALID & IN_READY;
  assign out_fire = main_valid & OUT_READY;

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  // Next state and slot controls; FLUSH overrides every handshake.
  always_comb begin
    state_d    = state_q;
    main_load  = 1'b0;
    main_clear = 1'b0;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (FLUSH) begin
      state_d    = ST_EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_load = 1'b1;
            state_d   = ST_ONE;
          end
        end
        ST_ONE: begin
          case ({in_fire, out_fire})
            2'b10: begin
              skid_load = 1'b1;
              state_d   = ST_FULL;
            end
            2'b01: begin
              main_clear = 1'b1;
              state_d    = ST_EMPTY;
            end
            2'b11:   main_load = 1'b1;
            default: ;
          endcase
        end
        ST_FULL: begin
          if (out_fire) begin
            main_load  = 1'b1;
            skid_clear = 1'b1;
            state_d    = ST_ONE;
          end
        end
        default: begin
          main_clear = 1'b1;
          skid_clear = 1'b1;
          state_d    = ST_EMPTY;
        end
      endcase
    end
    in_ready_d = (state_d != ST_FULL);
  end

  // The main slot refills from the skid slot whenever the skid holds an entry.
  assign main_in_data = skid_valid ? skid_data : IN_DATA;
  assign main_in_ctrl = skid_valid ? skid_ctrl : IN_CTRL;

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk     (CLK),
    .reset   (RESET),
    .load    (main_load),
    .clear   (main_clear),
    .in_data (main_in_data),
    .in_ctrl (main_in_ctrl),
    .valid   (main_valid),
    .data    (main_data),
    .ctrl    (main_ctrl)
  );

  if (SKID_EN != 0) begin : g_skid
    logic in_ready_q;

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
      .clk     (CLK),
      .reset   (RESET),
      .load    (skid_load),
      .clear   (skid_clear),
      .in_data (IN_DATA),
      .in_ctrl (IN_CTRL),
      .valid   (skid_valid),
      .data    (skid_data),
      .ctrl    (skid_ctrl)
    );

    // Registered ready: high unless the stage will be full after this edge.
    always_ff @(posedge CLK) begin
      if (RESET) in_ready_q <= 1'b1;
      else       in_ready_q <= in_ready_d;
    end

    assign IN_READY = in_ready_q;
  end else begin : g_no_skid
    assign skid_valid = 1'b0;
    assign skid_data  = '0;
    assign skid_ctrl  = '0;
    assign IN_READY   = !main_valid | OUT_READY;
  end

  // Outputs: control is a bubble whenever nothing valid is held.
  always_comb begin
    OUT_VALID = main_valid;
    OUT_DATA  = main_data;
    OUT_CTRL  = main_valid ? main_ctrl : '0;
    OCCUPANCY = occupancy_of(state_q);
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a vector table for the skid build plus
// hand-written sequences for ready timing and the single-entry build.
module tb_pipe_stage_reg;

  typedef struct {
    logic        rst;
    logic        flush;
    logic        iv;
    logic [31:0] d;
    logic [15:0] c;
    logic        ordy;
    logic        eov;
    logic [31:0] eod;
    logic [15:0] eoc;
    logic        eir;
    logic [1:0]  eocc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_data;
  logic [15:0] in_ctrl;
  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [15:0] out_ctrl;
  logic [1:0]  occ;

  logic        rst0, flush0, in_valid0, out_ready0;
  logic [31:0] in_data0;
  logic [15:0] in_ctrl0;
  logic        in_ready0, out_valid0;
  logic [31:0] out_data0;
  logic [15:0] out_ctrl0;
  logic [1:0]  occ0;

  int total = 0;
  int bad   = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .SKID_EN(1)) dut (
    .CLK(clk), .RESET(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
    .IN_DATA(in_data), .IN_CTRL(in_ctrl), .FLUSH(flush),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_DATA(out_data),
    .OUT_CTRL(out_ctrl), .OCCUPANCY(occ)
  );

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .SKID_EN(0)) dut0 (
    .CLK(clk), .RESET(rst0), .IN_VALID(in_valid0), .IN_READY(in_ready0),
    .IN_DATA(in_data0), .IN_CTRL(in_ctrl0), .FLUSH(flush0),
    .OUT_VALID(out_valid0), .OUT_READY(out_ready0), .OUT_DATA(out_data0),
    .OUT_CTRL(out_ctrl0), .OCCUPANCY(occ0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic f, input logic iv, input logic [31:0] d,
                     input logic [15:0] c, input logic ordy, input logic eov,
                     input logic [31:0] eod, input logic [15:0] eoc, input logic eir,
                     input logic [1:0] eocc);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.d = d; v.c = c; v.ordy = ordy;
    v.eov = eov; v.eod = eod; v.eoc = eoc; v.eir = eir; v.eocc = eocc;
    vq.push_back(v);
  endtask

  task automatic check_dut(input string tag, input logic eov, input logic [31:0] eod,
                           input logic [15:0] eoc, input logic eir, input logic [1:0] eocc);
    check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, eov});
    check({tag, ".out_data"},  out_data, eod);
    check({tag, ".out_ctrl"},  {16'd0, out_ctrl}, {16'd0, eoc});
    check({tag, ".in_ready"},  {31'd0, in_ready}, {31'd0, eir});
    check({tag, ".occupancy"}, {30'd0, occ}, {30'd0, eocc});
  endtask

  task automatic check_dut0(input string tag, input logic eov, input logic [31:0] eod,
                            input logic [15:0] eoc, input logic [1:0] eocc);
    check({tag, ".out_valid"}, {31'd0, out_valid0}, {31'd0, eov});
    check({tag, ".out_data"},  out_data0, eod);
    check({tag, ".out_ctrl"},  {16'd0, out_ctrl0}, {16'd0, eoc});
    check({tag, ".occupancy"}, {30'd0, occ0}, {30'd0, eocc});
  endtask

  task automatic drive(input logic r, input logic f, input logic iv, input logic [31:0] d,
                       input logic [15:0] c, input logic ordy);
    rst = r; flush = f; in_valid = iv; in_data = d; in_ctrl = c; out_ready = ordy;
  endtask

  task automatic drive0(input logic r, input logic iv, input logic [31:0] d,
                        input logic [15:0] c, input logic ordy);
    rst0 = r; flush0 = 1'b0; in_valid0 = iv; in_data0 = d; in_ctrl0 = c; out_ready0 = ordy;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 32'd0, 16'd0, 1'b0);
    drive0(1'b1, 1'b0, 32'd0, 16'd0, 1'b0);

    //   rst flush iv  data   ctrl      ordy | ov  odata  octrl     ir  occ
    // Reset held two edges with a payload presented
    add(1, 0, 1, 32'hDEAD, 16'hFFFF, 1,   0, 32'd0,   16'h0000, 1, 0);
    add(1, 0, 1, 32'hDEAD, 16'hFFFF, 1,   0, 32'd0,   16'h0000, 1, 0);
    // Bubble: nothing offered while empty
    add(0, 0, 0, 32'd0,    16'h0000, 1,   0, 32'd0,   16'h0000, 1, 0);
    // Streaming
    add(0, 0, 1, 32'd104,  16'h0011, 1,   1, 32'd104, 16'h0011, 1, 1);
    add(0, 0, 1, 32'd204,  16'h0022, 1,   1, 32'd204, 16'h0022, 1, 1);
    add(0, 0, 1, 32'd304,  16'h0033, 1,   1, 32'd304, 16'h0033, 1, 1);
    add(0, 0, 0, 32'd0,    16'h0000, 1,   0, 32'd304, 16'h0000, 1, 0);
    // Backpressure into the skid slot, offer refused while full, drain
    add(0, 0, 1, 32'd42,   16'h0042, 0,   1, 32'd42,  16'h0042, 1, 1);
    add(0, 0, 1, 32'd84,   16'h0084, 0,   1, 32'd42,  16'h0042, 0, 2);
    add(0, 0, 1, 32'd77,   16'h0077, 0,   1, 32'd42,  16'h0042, 0, 2);
    add(0, 0, 0, 32'd0,    16'h0000, 1,   1, 32'd84,  16'h0084, 1, 1);
    add(0, 0, 0, 32'd0,    16'h0000, 1,   0, 32'd84,  16'h0000, 1, 0);
    // Flush from full, data retained, 99 never enters
    add(0, 0, 1, 32'd42,   16'h0042, 0,   1, 32'd42,  16'h0042, 1, 1);
    add(0, 0, 1, 32'd84,   16'h0084, 0,   1, 32'd42,  16'h0042, 0, 2);
    add(0, 1, 1, 32'd99,   16'h0099, 0,   0, 32'd42,  16'h0000, 1, 0);
    // Flush discards a same-cycle input fire
    add(0, 0, 1, 32'd55,   16'h0055, 1,   1, 32'd55,  16'h0055, 1, 1);
    add(0, 1, 1, 32'd99,   16'h0099, 1,   0, 32'd55,  16'h0000, 1, 0);
    add(0, 0, 0, 32'd0,    16'h0000, 1,   0, 32'd55,  16'h0000, 1, 0);
    // Mid-operation reset from full (reset beats flush), then idle
    add(0, 0, 1, 32'd42,   16'h0042, 0,   1, 32'd42,  16'h0042, 1, 1);
    add(0, 0, 1, 32'd84,   16'h0084, 0,   1, 32'd42,  16'h0042, 0, 2);
    add(1, 1, 1, 32'd99,   16'h0099, 1,   0, 32'd0,   16'h0000, 1, 0);
    add(0, 0, 0, 32'd0,    16'h0000, 1,   0, 32'd0,   16'h0000, 1, 0);
    // Full with output fire: skid moves to main, new offer refused, then taken
    add(0, 0, 1, 32'd11,   16'h0101, 0,   1, 32'd11,  16'h0101, 1, 1);
    add(0, 0, 1, 32'd22,   16'h0202, 0,   1, 32'd11,  16'h0101, 0, 2);
    add(0, 0, 1, 32'd33,   16'h0303, 1,   1, 32'd22,  16'h0202, 1, 1);
    add(0, 0, 1, 32'd33,   16'h0303, 1,   1, 32'd33,  16'h0303, 1, 1);
    add(0, 0, 0, 32'd0,    16'h0000, 0,   1, 32'd33,  16'h0303, 1, 1);
    add(0, 0, 0, 32'd0,    16'h0000, 1,   0, 32'd33,  16'h0000, 1, 0);

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].rst, vq[i].flush, vq[i].iv, vq[i].d, vq[i].c, vq[i].ordy);
      @(posedge clk);
      #1;
      check_dut($sformatf("v%0d", i), vq[i].eov, vq[i].eod, vq[i].eoc, vq[i].eir, vq[i].eocc);
    end

    // IN_READY is registered: raising OUT_READY while full must not lift it before the edge.
    @(negedge clk); drive(0, 0, 1, 32'h500, 16'h0005, 0);
    @(negedge clk); drive(0, 0, 1, 32'h600, 16'h0006, 0);
    @(negedge clk); drive(0, 0, 0, 32'h0,   16'h0000, 1);
    #1;
    check("seq_reg_ready.in_ready_before_edge", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    check_dut("seq_reg_ready.after_pop", 1'b1, 32'h600, 16'h0006, 1'b1, 2'd1);
    @(negedge clk); drive(0, 0, 0, 32'h0, 16'h0000, 1);
    @(posedge clk); #1;
    check_dut("seq_reg_ready.drained", 1'b0, 32'h600, 16'h0000, 1'b1, 2'd0);

    // Single-entry build: combinational ready, replacement in the same cycle.
    @(negedge clk); drive0(1, 0, 32'h0, 16'h0, 1);
    @(posedge clk); #1;
    check_dut0("nsk.reset", 1'b0, 32'h0, 16'h0, 2'd0);
    @(negedge clk); drive0(0, 1, 32'hA1, 16'h00A1, 0);
    @(posedge clk); #1;
    check_dut0("nsk.load", 1'b1, 32'hA1, 16'h00A1, 2'd1);
    @(negedge clk); drive0(0, 1, 32'hB2, 16'h00B2, 0);
    #1;
    check("nsk.in_ready_blocked", {31'd0, in_ready0}, 32'd0);
    out_ready0 = 1'b1;
    #1;
    check("nsk.in_ready_comb", {31'd0, in_ready0}, 32'd1);
    @(posedge clk); #1;
    check_dut0("nsk.replace", 1'b1, 32'hB2, 16'h00B2, 2'd1);
    @(negedge clk); drive0(0, 1, 32'hC3, 16'h00C3, 0);
    @(posedge clk); #1;
    check_dut0("nsk.hold", 1'b1, 32'hB2, 16'h00B2, 2'd1);
    @(negedge clk); drive0(0, 0, 32'h0, 16'h0, 1);
    @(posedge clk); #1;
    check_dut0("nsk.drain", 1'b0, 32'hB2, 16'h0, 2'd0);
    check("nsk.in_ready_empty", {31'd0, in_ready0}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
